// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
// Instruction handshake between an instruction source and the sequencer.
//   ins_valid : source -> sequencer, ins_data holds a valid instruction word
//   ins_data  : source -> sequencer, [23:20] opcode, [19:16] op1, [15:12] op2,
//               [15:0] data
//   ins_ready : sequencer -> source, an instruction is accepted this cycle
// -----------------------------------------------------------------------------
interface instr_sequencer_if;
  localparam int unsigned INS_W = 24;

  logic             ins_valid;
  logic [INS_W-1:0] ins_data;
  logic             ins_ready;

  modport master (output ins_valid, output ins_data, input ins_ready);
  modport slave  (input ins_valid, input ins_data, output ins_ready);
endinterface

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle control FSM for the bus-based RISC datapath. Captures one
// instruction per handshake and walks the 5-bit state codes consumed by the
// output decoder. Owns the MINALL loop index.
//
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : instr_sequencer_if.slave (ins_valid, ins_data, ins_ready)
//   state   : state code to the output decoder
//   func    : registered instruction word
//   count   : MINALL loop index
//   alu_op  : ALU function select, held for the whole instruction
//   busy    : high in every state except IDLE and FETCH
//   illegal : one-cycle pulse (in DECODE) for an undefined opcode
//
// Optional feature macro: SEQ_HALT_EN
//   defined   : opcode F enters HALT (5'b11111), left only by rst
//   undefined : opcode F is illegal like B..E
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int unsigned MINALL_LAST = 15,
  parameter int unsigned ALU_OP_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  instr_sequencer_if.slave    bus,
  output logic [4:0]          state,
  output logic [23:0]         func,
  output logic [3:0]          count,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                busy,
  output logic                illegal
);

  localparam int unsigned STATE_W = 5;
  localparam int unsigned INS_W   = 24;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OP_W    = 4;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MINALL_LAST);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 5'b00000,
    S_FETCH   = 5'b00001,
    S_DECODE  = 5'b00010,
    S_ALU0    = 5'b00011,
    S_ALU1    = 5'b00100,
    S_ALU2    = 5'b00101,
    S_LOAD    = 5'b00110,
    S_MOVE    = 5'b00111,
    S_LDPC    = 5'b01000,
    S_BRANCH  = 5'b01001,
    S_MA_INIT = 5'b01010,
    S_MA_A    = 5'b01011,
    S_MA_B    = 5'b01100,
    S_MA_END  = 5'b01101,
    S_HALT    = 5'b11111
  } state_e;

  state_e              r_state;
  state_e              w_nxt_state;
  logic [INS_W-1:0]    r_func;
  logic [INS_W-1:0]    w_func_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [ALU_OP_W-1:0] w_alu_op_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_ready;
  logic                w_ready_nxt;
  logic                r_illegal;
  logic                w_illegal_nxt;

  logic [OP_W-1:0]     w_opcode;
  logic [OP_W-1:0]     w_in_opcode;
  logic                w_capture;
  logic                w_in_illegal;
  logic                w_in_alu;

  assign w_opcode    = r_func[23:20];
  assign w_in_opcode = bus.ins_data[23:20];
  assign w_capture   = (r_state == S_FETCH) && bus.ins_valid;
  assign w_in_alu    = (w_in_opcode >= 4'h3) && (w_in_opcode <= 4'h7);

  // Undefined opcodes are flagged at capture so the pulse lines up with DECODE
`ifdef SEQ_HALT_EN
  assign w_in_illegal = (w_in_opcode >= 4'hB) && (w_in_opcode != 4'hF);
`else
  assign w_in_illegal = (w_in_opcode >= 4'hB);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt_state;
  end

  // Next-state logic
  always_comb begin
    w_nxt_state = S_IDLE;
    case (r_state)
      S_IDLE:   w_nxt_state = S_FETCH;
      S_FETCH:  w_nxt_state = bus.ins_valid ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_opcode)
          4'h0:                         w_nxt_state = S_FETCH;
          4'h1:                         w_nxt_state = S_LOAD;
          4'h2:                         w_nxt_state = S_MOVE;
          4'h3, 4'h4, 4'h5, 4'h6, 4'h7: w_nxt_state = S_ALU0;
          4'h8:                         w_nxt_state = S_LDPC;
          4'h9:                         w_nxt_state = S_BRANCH;
          4'hA:                         w_nxt_state = S_MA_INIT;
`ifdef SEQ_HALT_EN
          4'hF:                         w_nxt_state = S_HALT;
`endif
          default:                      w_nxt_state = S_FETCH;
        endcase
      end
      S_ALU0:    w_nxt_state = S_ALU1;
      S_ALU1:    w_nxt_state = S_ALU2;
      S_ALU2:    w_nxt_state = S_FETCH;
      S_LOAD:    w_nxt_state = S_FETCH;
      S_MOVE:    w_nxt_state = S_FETCH;
      S_LDPC:    w_nxt_state = S_FETCH;
      S_BRANCH:  w_nxt_state = S_FETCH;
      S_MA_INIT: w_nxt_state = S_MA_A;
      S_MA_A:    w_nxt_state = S_MA_B;
      S_MA_B:    w_nxt_state = (r_count == LAST_IDX) ? S_MA_END : S_MA_A;
      S_MA_END:  w_nxt_state = S_FETCH;
`ifdef SEQ_HALT_EN
      S_HALT:    w_nxt_state = S_HALT;
`endif
      // Unreachable codes (and HALT when the feature is off) recover to IDLE
      default:   w_nxt_state = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, keyed off the
  // next state so every output is aligned with the state it describes
  always_comb begin
    w_func_nxt    = r_func;
    w_alu_op_nxt  = r_alu_op;
    w_count_nxt   = r_count;
    w_illegal_nxt = 1'b0;
    w_ready_nxt   = (w_nxt_state == S_FETCH);
    w_busy_nxt    = !((w_nxt_state == S_IDLE) || (w_nxt_state == S_FETCH));

    if (w_capture) begin
      w_func_nxt    = bus.ins_data;
      w_alu_op_nxt  = w_in_alu ? ALU_OP_W'(w_in_opcode - 4'h3) : '0;
      w_illegal_nxt = w_in_illegal;
    end

    // MINALL index: starts at 1, steps on each loop-back from the check state
    if (w_nxt_state == S_MA_INIT) begin
      w_count_nxt = CNT_W'(1);
    end else if ((r_state == S_MA_B) && (w_nxt_state == S_MA_A)) begin
      w_count_nxt = r_count + CNT_W'(1);
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_func    <= '0;
      r_count   <= '0;
      r_alu_op  <= '0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_func    <= w_func_nxt;
      r_count   <= w_count_nxt;
      r_alu_op  <= w_alu_op_nxt;
      r_busy    <= w_busy_nxt;
      r_ready   <= w_ready_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign state         = r_state;
  assign func          = r_func;
  assign count         = r_count;
  assign alu_op        = r_alu_op;
  assign busy          = r_busy;
  assign illegal       = r_illegal;
  assign bus.ins_ready = r_ready;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Scoreboard bench for instr_sequencer. Two instances: MINALL_LAST=15 (sel=0)
// and MINALL_LAST=1 (sel=1). Expected per-cycle records are pushed when an
// instruction is driven and popped at every falling edge.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [23:0] JUNK = 24'hB5A5A5;

  logic        sel      = 1'b0;
  logic        tb_valid = 1'b0;
  logic [23:0] tb_data  = 24'h0;

  instr_sequencer_if if0 ();
  instr_sequencer_if if1 ();

  assign if0.ins_valid = tb_valid && !sel;
  assign if0.ins_data  = tb_data;
  assign if1.ins_valid = tb_valid && sel;
  assign if1.ins_data  = tb_data;

  logic [4:0]  st0, st1;
  logic [23:0] fn0, fn1;
  logic [3:0]  cn0, cn1;
  logic [2:0]  ao0, ao1;
  logic        by0, by1, il0, il1;

  instr_sequencer #(.MINALL_LAST(15), .ALU_OP_W(3)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .state(st0), .func(fn0), .count(cn0),
    .alu_op(ao0), .busy(by0), .illegal(il0)
  );

  instr_sequencer #(.MINALL_LAST(1), .ALU_OP_W(3)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .state(st1), .func(fn1), .count(cn1),
    .alu_op(ao1), .busy(by1), .illegal(il1)
  );

  logic [4:0]  o_state;
  logic [23:0] o_func;
  logic [3:0]  o_count;
  logic [2:0]  o_alu_op;
  logic        o_busy, o_ready, o_illegal;

  assign o_state   = sel ? st1 : st0;
  assign o_func    = sel ? fn1 : fn0;
  assign o_count   = sel ? cn1 : cn0;
  assign o_alu_op  = sel ? ao1 : ao0;
  assign o_busy    = sel ? by1 : by0;
  assign o_ready   = sel ? if1.ins_ready : if0.ins_ready;
  assign o_illegal = sel ? il1 : il0;

  typedef struct {
    logic [4:0]  state;
    logic [23:0] func;
    logic [3:0]  count;
    logic [2:0]  alu_op;
    logic        chk_alu;
    logic        busy;
    logic        ready;
    logic        illegal;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_count [2];

  // Scoreboard: one expected record per falling edge while the queue is non-empty
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tests_run++;
      if (o_state !== e.state) begin
        tests_failed++;
        $display("FAIL sb_state: got %b expected %b", o_state, e.state);
      end
      tests_run++;
      if (o_func !== e.func) begin
        tests_failed++;
        $display("FAIL sb_func (state %b): got %h expected %h", e.state, o_func, e.func);
      end
      tests_run++;
      if (o_count !== e.count) begin
        tests_failed++;
        $display("FAIL sb_count (state %b): got %0d expected %0d", e.state, o_count, e.count);
      end
      tests_run++;
      if (o_busy !== e.busy) begin
        tests_failed++;
        $display("FAIL sb_busy (state %b): got %b expected %b", e.state, o_busy, e.busy);
      end
      tests_run++;
      if (o_ready !== e.ready) begin
        tests_failed++;
        $display("FAIL sb_ready (state %b): got %b expected %b", e.state, o_ready, e.ready);
      end
      tests_run++;
      if (o_illegal !== e.illegal) begin
        tests_failed++;
        $display("FAIL sb_illegal (state %b): got %b expected %b", e.state, o_illegal, e.illegal);
      end
      if (e.chk_alu) begin
        tests_run++;
        if (o_alu_op !== e.alu_op) begin
          tests_failed++;
          $display("FAIL sb_alu_op (state %b): got %0d expected %0d", e.state, o_alu_op, e.alu_op);
        end
      end
    end
  end

  // Reference model: per-cycle records from DECODE through the return to FETCH
  task automatic push_instr(input logic [23:0] ins, input logic s);
    exp_t       e;
    logic [3:0] op;
    int         last;
    op         = ins[23:20];
    last       = s ? 1 : 15;
    e.func     = ins;
    e.busy     = 1'b1;
    e.ready    = 1'b0;
    e.chk_alu  = (op >= 4'h3) && (op <= 4'h7);
    e.alu_op   = e.chk_alu ? 3'(op - 4'h3) : 3'd0;
    e.count    = m_count[s];
    e.state    = 5'b00010;
`ifdef SEQ_HALT_EN
    e.illegal  = (op >= 4'hB) && (op != 4'hF);
`else
    e.illegal  = (op >= 4'hB);
`endif
    sb_q.push_back(e);
    e.illegal = 1'b0;
    case (op)
      4'h1: begin e.state = 5'b00110; sb_q.push_back(e); end
      4'h2: begin e.state = 5'b00111; sb_q.push_back(e); end
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        e.state = 5'b00011; sb_q.push_back(e);
        e.state = 5'b00100; sb_q.push_back(e);
        e.state = 5'b00101; sb_q.push_back(e);
      end
      4'h8: begin e.state = 5'b01000; sb_q.push_back(e); end
      4'h9: begin e.state = 5'b01001; sb_q.push_back(e); end
      4'hA: begin
        e.count = 4'd1;
        e.state = 5'b01010; sb_q.push_back(e);
        for (int k = 1; k <= last; k++) begin
          e.count = 4'(k);
          e.state = 5'b01011; sb_q.push_back(e);
          e.state = 5'b01100; sb_q.push_back(e);
        end
        e.count = 4'(last);
        e.state = 5'b01101; sb_q.push_back(e);
        m_count[s] = 4'(last);
      end
      default: ;
    endcase
    e.state = 5'b00001;
    e.busy  = 1'b0;
    e.ready = 1'b1;
    sb_q.push_back(e);
  endtask

  // Drives a program with ins_valid held high; junk data outside FETCH
  task automatic run_prog(input logic [23:0] prog[$], input logic s);
    int n;
    sel = s;
    foreach (prog[i]) begin
      tb_data  = prog[i];
      tb_valid = 1'b1;
      push_instr(prog[i], s);
      n = 0;
      while (sb_q.size() > 0 && n < 200) begin
        @(negedge clk); #1;
        tb_data = JUNK;
        n++;
      end
      if (sb_q.size() > 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL run_timeout: %0d records left, required 0", sb_q.size());
        sb_q.delete();
      end
    end
    tb_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    tests_run++;
    if (st0 !== 5'b00000 || st1 !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_state: got %b/%b expected 00000", st0, st1);
    end
    tests_run++;
    if ({fn0, cn0, ao0, by0, il0, if0.ins_ready} !== 34'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got func=%h count=%0d alu_op=%0d busy=%b illegal=%b ready=%b expected all 0",
               fn0, cn0, ao0, by0, il0, if0.ins_ready);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    m_count[0] = 4'd0;
    m_count[1] = 4'd0;
    @(negedge clk); #1;
    tests_run++;
    if (st0 !== 5'b00001 || if0.ins_ready !== 1'b1 || st1 !== 5'b00001) begin
      tests_failed++;
      $display("FAIL reset_to_fetch: got state %b/%b ready %b expected 00001 ready 1",
               st0, st1, if0.ins_ready);
    end
  endtask

  task automatic test_alu;
    logic [23:0] p[$];
    p.push_back(24'h312000);
    run_prog(p, 1'b0);
    p.delete(); p.push_back(24'h4A3123);
    run_prog(p, 1'b0);
    p.delete(); p.push_back(24'h7FFFFF);
    run_prog(p, 1'b0);
  endtask

  task automatic test_single_cycle;
    logic [23:0] p[$];
    p.push_back(24'h1C0ABC);
    p.push_back(24'h800042);
    p.push_back(24'h055555);
    run_prog(p, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [23:0] p[$];
    p.push_back(24'h245000);
    p.push_back(24'h970000);
    run_prog(p, 1'b0);
  endtask

  task automatic test_minall;
    logic [23:0] p[$];
    p.push_back(24'hA00000);
    p.push_back(24'h000000);
    run_prog(p, 1'b0);
    p.delete();
    p.push_back(24'hA00000);
    p.push_back(24'h312000);
    run_prog(p, 1'b1);
    sel = 1'b0;
  endtask

  task automatic test_illegal;
    logic [23:0] p[$];
    p.push_back(24'hB12345);
    p.push_back(24'hD00000);
    run_prog(p, 1'b0);
  endtask

  task automatic test_opcode_f;
`ifdef SEQ_HALT_EN
    exp_t e;
    int   n;
    sel       = 1'b0;
    tb_data   = 24'hF00000;
    tb_valid  = 1'b1;
    e.func    = 24'hF00000;
    e.count   = m_count[0];
    e.alu_op  = 3'd0;
    e.chk_alu = 1'b0;
    e.busy    = 1'b1;
    e.ready   = 1'b0;
    e.illegal = 1'b0;
    e.state   = 5'b00010;
    sb_q.push_back(e);
    e.state   = 5'b11111;
    for (int k = 0; k < 100; k++) sb_q.push_back(e);
    n = 0;
    while (sb_q.size() > 0 && n < 300) begin
      @(negedge clk); #1;
      tb_valid = 1'b0;
      n++;
    end
    if (sb_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL halt_timeout: %0d records left, required 0", sb_q.size());
      sb_q.delete();
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (st0 !== 5'b00000) begin
      tests_failed++;
      $display("FAIL halt_reset: got %b expected 00000", st0);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    m_count[0] = 4'd0;
    m_count[1] = 4'd0;
    @(negedge clk); #1;
    tests_run++;
    if (st0 !== 5'b00001) begin
      tests_failed++;
      $display("FAIL halt_recover: got %b expected 00001", st0);
    end
`else
    logic [23:0] p[$];
    p.push_back(24'hF00000);
    run_prog(p, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_alu;
    int n;
    sel      = 1'b0;
    tb_data  = 24'h312000;
    tb_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #1;
      tb_valid = 1'b0;
      n++;
    end while (st0 !== 5'b00100 && n < 10);
    tests_run++;
    if (st0 !== 5'b00100) begin
      tests_failed++;
      $display("FAIL mid_alu_reach: got %b expected 00100", st0);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (st0 !== 5'b00000 || by0 !== 1'b0 || fn0 !== 24'h0 || ao0 !== 3'd0) begin
      tests_failed++;
      $display("FAIL mid_alu_reset: got state=%b busy=%b func=%h alu_op=%0d expected 00000/0/000000/0",
               st0, by0, fn0, ao0);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    m_count[0] = 4'd0;
    m_count[1] = 4'd0;
    @(negedge clk); #1;
    tests_run++;
    if (st0 !== 5'b00001 || if0.ins_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_alu_fetch: got state=%b ready=%b expected 00001/1", st0, if0.ins_ready);
    end
  endtask

  initial begin
    m_count[0] = 4'd0;
    m_count[1] = 4'd0;
    #1;
    test_reset();
    test_alu();
    test_single_cycle();
    test_back_to_back();
    test_minall();
    test_illegal();
    test_opcode_f();
    test_reset_mid_alu();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM for the bus-based RISC datapath.
- Accepts one 24-bit instruction word per handshake and holds it in a register.
- Steps through the 5-bit state codes that drive the output decoder, which turns each code into register-enable and tristate-enable vectors, branch and pc_enable.
- Owns the MINALL loop index, so the decoder's own count is only mirrored, never relied on for sequencing.

Parameters:
- MINALL_LAST, 15: last register index visited by MINALL; legal range 1..15.
- ALU_OP_W, 3: width of the alu_op output.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous active-high reset
- ins_valid  input  1  instruction word on ins_data is valid
- ins_data  input  24  instruction: [23:20] opcode, [19:16] op1, [15:12] op2, [15:0] data
- ins_ready  output  1  sequencer can accept an instruction; high only in FETCH
- state  output  5  state code to the output decoder
- func  output  24  registered instruction, to the output decoder
- count  output  4  MINALL loop index, for debug and cross-check
- alu_op  output  ALU_OP_W  ALU function select; held for the whole instruction
- busy  output  1  high in every state except IDLE and FETCH
- illegal  output  1  one-cycle pulse when an undefined opcode is decoded

Behaviour:
- Reset: asynchronous.
  - state=5'b00000 (IDLE); func=0, count=0, alu_op=0, illegal=0.
  - ins_ready=0, busy=0.
  - Reset asserted mid-instruction aborts it immediately; there is no partial writeback beyond what was already clocked.
- IDLE (00000): always goes to FETCH on the next cycle.
- FETCH (00001): ins_ready=1.
  - ins_valid=1: capture ins_data into func, go to DECODE.
  - ins_valid=0: stay in FETCH.
- DECODE (00010): dispatch on func[23:20].
  - 0 NOP -> FETCH.
  - 1 LOAD -> 00110.
  - 2 MOVE -> 00111.
  - 3..7 ALU -> 00011; alu_op = opcode-3 (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR).
  - 8 LDPC -> 01000.
  - 9 BRANCH -> 01001.
  - A MINALL -> 01010.
  - B..F -> illegal=1 for one cycle, then FETCH; no datapath state is entered.
- ALU sequence: 00011 -> 00100 -> 00101 -> FETCH, one cycle each.
- Single-cycle sequences: LOAD 00110, MOVE 00111, LDPC 01000 and BRANCH 01001 each last one cycle, then FETCH.
- MINALL sequence:
  - 01010: count=1.
  - 01011 then 01100.
  - In 01100: if count==MINALL_LAST go to 01101, else count=count+1 and go to 01011.
  - 01101: one cycle, then FETCH; count is held until the next MINALL.
  - Total length is 2*MINALL_LAST+2 cycles.
- Latency: FETCH handshake to first datapath state is 2 cycles (capture, then DECODE). Instruction totals including FETCH and DECODE:
  - ALU: 5 cycles.
  - LOAD/MOVE/LDPC/BRANCH: 3 cycles.
  - MINALL: 2*MINALL_LAST+4 cycles.
- Stability and handshake rules:
  - func and alu_op are stable from DECODE until the next FETCH capture.
  - ins_data is ignored outside FETCH.
  - ins_valid held high continuously gives back-to-back instructions with no bubble beyond FETCH.
- Any unreachable state code recovers to IDLE on the next edge.

Optional Feature:
- Macro: SEQ_HALT_EN.
- Defined:
  - Opcode F enters HALT (state 11111); the output decoder's default case disables all enables.
  - busy=1, ins_ready=0.
  - HALT is left only by rst.
  - Opcode F does not pulse illegal.
- Undefined: opcode F is illegal, as for B..E.

Test Plan:
- Reset: assert rst mid-ALU (state 00100) -> state=00000, busy=0, func=0 asynchronously; then IDLE -> FETCH next edge, ins_ready=1.
- ALU: ins_data=24'h312000 (ADD r1,r2) accepted in FETCH -> states 00010, 00011, 00100, 00101, 00001; alu_op=0 throughout; func=24'h312000.
- Back-to-back: ins_valid held high with MOVE 24'h245000 then BRANCH 24'h970000 -> state sequence 00001,00010,00111,00001,00010,01001,00001.
- MINALL, MINALL_LAST=15: 24'hA00000 -> 01010, then 15 pairs of 01011/01100 with count stepping 1..15, then 01101 with count=15; total 32 cycles from 01010 to FETCH.
- MINALL, MINALL_LAST=1: 24'hA00000 -> 01010, 01011, 01100, 01101, 00001.
- Illegal and halt: opcode B -> illegal=1 for exactly one cycle in DECODE, then FETCH. Opcode F with SEQ_HALT_EN -> state 11111 held for 100 cycles until rst. Opcode F without SEQ_HALT_EN -> illegal pulse, then FETCH.
